// File: rtl/timed_switch_bank.sv
// Bank of independent timed switches: per-channel period/on-time counters with continuous and one-shot modes.
// Optional dead-time on init-to-~init transitions is enabled with `define TSW_DEADTIME_EN.
//
// state | meaning
// IDLE  | channel halted, sw = init, configuration writes accepted
// RUN   | count cycles 0..P-1, sw = ~init while count < T, writes rejected
module timed_switch_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int DEAD     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [1:0]          wr_addr,
  input  logic [CNT_W-1:0]    wr_data,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic                wr_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [CNT_W-1:0]    period_q [CHANNELS];
  logic [CNT_W-1:0]    period_d [CHANNELS];
  logic [CNT_W-1:0]    ontime_q [CHANNELS];
  logic [CNT_W-1:0]    ontime_d [CHANNELS];
  logic [CNT_W-1:0]    count_q  [CHANNELS];
  logic [CNT_W-1:0]    count_d  [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] init_q, init_d;
  logic [CHANNELS-1:0] sw_d, done_d;
  logic                wr_err_d;
  logic                wr_oob;

  assign wr_oob = ({1'b0, wr_ch} >= 5'(CHANNELS));

  // Writes are folded into the effective config first, so a same-cycle start sees the new values.
  always_comb begin
    logic             wr_hit;
    logic             on;
    logic [CNT_W-1:0] last;
    wr_hit   = 1'b0;
    on       = 1'b0;
    last     = '0;
    wr_err_d = wr_en && (wr_oob || (wr_addr == 2'd3));
    mode_d   = mode_q;
    init_d   = init_q;
    sw_d     = '0;
    done_d   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      period_d[ch] = period_q[ch];
      ontime_d[ch] = ontime_q[ch];
      state_d[ch]  = state_q[ch];
      count_d[ch]  = count_q[ch];

      wr_hit = wr_en && (wr_ch == 4'(ch)) && (wr_addr != 2'd3);
      if (wr_hit) begin
        if (state_q[ch] == RUN) begin
          wr_err_d = 1'b1;
        end else begin
          case (wr_addr)
            2'd0:    period_d[ch] = wr_data;
            2'd1:    ontime_d[ch] = wr_data;
            2'd2:    begin
              mode_d[ch] = wr_data[1];
              init_d[ch] = wr_data[0];
            end
            default: ;
          endcase
        end
      end

      last = period_q[ch] - CNT_W'(1);
      if (stop[ch]) begin
        state_d[ch] = IDLE;
        count_d[ch] = '0;
      end else if (state_q[ch] == RUN) begin
        if (count_q[ch] == last) begin
          count_d[ch] = '0;
          if (mode_q[ch]) state_d[ch] = IDLE;
        end else begin
          count_d[ch] = count_q[ch] + CNT_W'(1);
        end
      end else if (start[ch]) begin
        if (period_d[ch] != '0) begin
          state_d[ch] = RUN;
          count_d[ch] = '0;
        end else begin
          wr_err_d = 1'b1;
        end
      end

      on = (state_d[ch] == RUN) && (count_d[ch] < ontime_d[ch]);
`ifdef TSW_DEADTIME_EN
      // Already-active output stays active across a wrap; only a fresh turn-on waits DEAD cycles.
      on = on && ((count_d[ch] >= CNT_W'(DEAD)) ||
                  ((state_q[ch] == RUN) && (sw[ch] != init_q[ch])));
`endif
      sw_d[ch]   = on ? ~init_d[ch] : init_d[ch];
      done_d[ch] = (state_d[ch] == RUN) && mode_d[ch] &&
                   (count_d[ch] == period_d[ch] - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= IDLE;
        period_q[ch] <= '0;
        ontime_q[ch] <= '0;
        count_q[ch]  <= '0;
      end
      mode_q <= '0;
      init_q <= '0;
      sw     <= '0;
      done   <= '0;
      wr_err <= 1'b0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= state_d[ch];
        period_q[ch] <= period_d[ch];
        ontime_q[ch] <= ontime_d[ch];
        count_q[ch]  <= count_d[ch];
      end
      mode_q <= mode_d;
      init_q <= init_d;
      sw     <= sw_d;
      done   <= done_d;
      wr_err <= wr_err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      busy[ch] = (state_q[ch] == RUN);
    end
  end

endmodule
